spi_slave: RTL and testbench
============================

# spi_slave

SPI slave front-end that sits between an external SPI master and the single-port SPI RAM. It deserialises MOSI frames into 10-bit command words (`din[9:8]` = command, `din[7:0]` = payload) and presents them to the RAM with a one-cycle `rx_valid` strobe. For read-data commands it captures the RAM's `tx_data` on `tx_valid` and serialises it back on MISO.

## Interface
- `DATA_W`, default 8: RAM data/address width. Frame width is `DATA_W+2`.
- `clk` input 1: system clock; SPI bits are sampled and driven one per `clk` edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `SS_n` input 1: slave select, active low; a high level ends or aborts a transaction.
- `MOSI` input 1: serial data in, MSB first.
- `MISO` output 1: serial data out, MSB first.
- `rx_data` output `DATA_W+2`: received command word, connects to RAM `din`.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data` input `DATA_W`: read data from the RAM (`dout`).
- `tx_valid` input 1: RAM read-data strobe.

## Operation
- State machine states:
  - IDLE.
  - CHK_CMD.
  - WRITE: frames with `din[9]`=0, i.e. commands 00 (write address) and 01 (write data).
  - READ_ADD: command 10.
  - READ_DATA: command 11.
- Internal flag `rd_addr_seen` selects the read state. It is set when a READ_ADD frame completes and cleared when READ_DATA latches `tx_data`.
- IDLE moves to CHK_CMD on the first edge at which `SS_n` is sampled 0.
- In CHK_CMD, `MOSI` is sampled as frame bit 9. The next state is:
  - WRITE if the bit is 0.
  - READ_ADD if the bit is 1 and `rd_addr_seen`=0.
  - READ_DATA if the bit is 1 and `rd_addr_seen`=1.
- In the WRITE/READ_* state, the remaining 9 bits (8..0) are shifted in on consecutive edges. Received bits pass to `rx_data` unmodified; the slave does not rewrite bit 8.
- When bit 0 is captured:
  - `rx_data` is loaded with the full word.
  - `rx_valid`=1 for exactly the following cycle.
- WRITE and READ_ADD then hold until `SS_n`=1, and then return to IDLE. Extra MOSI bits are ignored.
- READ_DATA, after the `rx_valid` strobe, waits for `tx_valid`.
  - When it arrives, `tx_data` is latched and `rd_addr_seen` is cleared.
  - `DATA_W` bits are then driven on MISO MSB first, one per edge.
  - MISO returns to 0 after the last bit.
  - The block then holds until `SS_n`=1.
- `tx_valid` in any other state, or before `rx_valid` of the current frame, is ignored.
- `SS_n`=1 in any non-IDLE state:
  - Next state is IDLE.
  - Partial frame is discarded, with no `rx_valid`.
  - MISO goes to 0 on the next edge.
  - `rd_addr_seen` is unchanged unless `tx_data` was already latched.
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, `rd_addr_seen`=0, counters 0.
- Reset mid-frame aborts immediately. No strobe is produced afterwards.

## Timing
- Edge E0: `SS_n` is sampled low; the block moves IDLE to CHK_CMD.
- Edge E1: bit 9 is sampled.
- Edges E2..E10: bits 8..0 are sampled.
- After E10: `rx_data` is valid and `rx_valid`=1 for the cycle E10–E11.
- Minimum frame-to-strobe latency is 11 edges from `SS_n` low.
- Read data: if `tx_valid` is sampled high at edge T, MISO carries `tx_data[DATA_W-1]` after T+1 and `tx_data[0]` after T+`DATA_W`.
- `rx_valid` is never asserted in two consecutive cycles.
- At least one IDLE cycle separates transactions.

## Structure
- Package `spi_pkg` holds:
  - State enum typedef `spi_state_e`.
  - Command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - Frame width localparam.
- There are no sub-modules. The shift register, bit counter and FSM live in `spi_slave`.

## Test plan
- Write address:
  - Stimulus: `SS_n` low, MOSI 00_1010_0101, `SS_n` high.
  - Response: one `rx_valid` with `rx_data`=10'h0A5, 11 edges after `SS_n` low; MISO stays 0.
- Write data:
  - Stimulus: MOSI 01_0011_1100.
  - Response: `rx_data`=10'h13C, single strobe, `rd_addr_seen` stays 0.
- Read sequence:
  - Stimulus: frame 10_0000_0111, then frame 11_0000_0000; the RAM returns `tx_valid` with `tx_data`=8'hC3 one cycle after the second `rx_valid`.
  - Response: MISO serialises 1,1,0,0,0,0,1,1 starting one edge after `tx_valid`.
  - A third read frame goes to READ_ADD.
- Abort:
  - Stimulus: `SS_n` high after 5 bits of a write frame.
  - Response: no `rx_valid`, state IDLE next edge; the next full frame is received correctly.
- Spurious `tx_valid`:
  - Stimulus: `tx_valid` pulse during WRITE or IDLE.
  - Response: MISO stays 0 and `rd_addr_seen` is unchanged.
- Reset:
  - Stimulus: `rst_n` low mid-READ_DATA serialisation.
  - Response: MISO=0, `rx_valid`=0 and `rd_addr_seen`=0 immediately.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end: FSM state encoding,
// RAM command codes and the default frame width.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned FRAME_W = 10;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises (DATA_W+2)-bit command frames for the SPI RAM and
// serialises RAM read data back on MISO after a read-data command.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int unsigned FW = DATA_W + 2;
    localparam int unsigned CW = $clog2(DATA_W + 2);
    localparam int unsigned TW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);
    localparam logic [TW-1:0] TX_LAST  = TW'(DATA_W);

    spi_state_e state, next_state;

    logic [FW-2:0]     shift;
    logic [CW-1:0]     bit_cnt;
    logic              frame_done;
    logic              rd_addr_seen;
    logic [DATA_W-1:0] tx_reg;
    logic [TW-1:0]     tx_cnt;
    logic              tx_busy;
    logic              tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!SS_n) next_state = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)              next_state = IDLE;
                else if (!MOSI)        next_state = WRITE;
                else if (rd_addr_seen) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            default: if (SS_n) next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift        <= '0;
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            tx_reg       <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE || SS_n) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_busy    <= 1'b0;
                tx_done    <= 1'b0;
                MISO       <= 1'b0;
            end else if (state == CHK_CMD) begin
                shift   <= {{(FW-2){1'b0}}, MOSI};
                bit_cnt <= '0;
            end else if (!frame_done) begin
                shift   <= {shift[FW-3:0], MOSI};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data    <= {shift, MOSI};
                    rx_valid   <= 1'b1;
                    frame_done <= 1'b1;
                    if (state == READ_ADD) rd_addr_seen <= 1'b1;
                end
            end else if (state == READ_DATA) begin
                // Only one tx_valid per read frame is honoured; later pulses are ignored.
                if (tx_busy) begin
                    if (tx_cnt == TX_LAST) begin
                        MISO    <= 1'b0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        MISO   <= tx_reg[DATA_W-1];
                        tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end else if (!tx_done && tx_valid) begin
                    tx_reg       <= tx_data;
                    tx_cnt       <= '0;
                    tx_busy      <= 1'b1;
                    rd_addr_seen <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: write/read frames, strobe
// latency, MISO serialisation, abort, spurious tx_valid and mid-read reset.
module tb_spi_slave;
    import spi_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                SS_n;
    logic                MOSI;
    logic                MISO;
    logic [FRAME_W-1:0]  rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int dbl_cnt = 0;
    int last_cyc = 0;
    int c_start = 0;
    logic [FRAME_W-1:0] last_rx = '0;
    logic prev_v = 1'b0;

    spi_slave #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            strobe_cnt = strobe_cnt + 1;
            last_rx    = rx_data;
            last_cyc   = cyc;
            if (prev_v) dbl_cnt = dbl_cnt + 1;
        end
        prev_v = rx_valid;
    end

    // Drives SS_n low and all frame bits; returns at the negedge of the strobe cycle.
    task automatic start_frame(input logic [FRAME_W-1:0] w);
        @(negedge clk);
        SS_n = 1'b0;
        c_start = cyc;
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            @(negedge clk);
            MOSI = w[i];
        end
        @(negedge clk);
        MOSI = 1'b0;
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [FRAME_W-1:0] w, input int hold, input logic tv,
                             output logic [FRAME_W-1:0] got, output int lat, output int nstr,
                             output spi_state_e st, output logic miso_hi);
        int s0;
        s0 = strobe_cnt;
        miso_hi = 1'b0;
        start_frame(w);
        st = dut.state;
        miso_hi = miso_hi | MISO;
        for (int k = 0; k < hold; k++) begin
            tx_valid = tv;
            tx_data  = 8'hFF;
            @(negedge clk);
            miso_hi = miso_hi | MISO;
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        end_frame();
        miso_hi = miso_hi | MISO;
        got  = last_rx;
        lat  = last_cyc - c_start;
        nstr = strobe_cnt - s0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: MISO=%b rx_valid=%b rx_data=%h, required 0 0 000", MISO, rx_valid, rx_data);
        end
        checks++;
        if (dut.state !== IDLE || dut.rd_addr_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d rd_addr_seen=%b, required IDLE 0", dut.state, dut.rd_addr_seen);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_addr();
        logic [FRAME_W-1:0] got; int lat; int nstr; spi_state_e st; logic mh;
        run_frame(10'b00_1010_0101, 3, 1'b0, got, lat, nstr, st, mh);
        checks++;
        if (got !== 10'h0A5 || nstr !== 1) begin
            errors++;
            $display("FAIL wr_addr_data: rx_data=%h strobes=%0d, required 0a5 1", got, nstr);
        end
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL wr_addr_latency: %0d edges, required 11", lat);
        end
        checks++;
        if (st !== WRITE || mh !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr_state_miso: state=%0d miso_seen=%b, required WRITE 0", st, mh);
        end
    endtask

    task automatic test_write_data();
        logic [FRAME_W-1:0] got; int lat; int nstr; spi_state_e st; logic mh;
        run_frame(10'b01_0011_1100, 2, 1'b0, got, lat, nstr, st, mh);
        checks++;
        if (got !== 10'h13C || nstr !== 1 || dut.rd_addr_seen !== 1'b0) begin
            errors++;
            $display("FAIL wr_data: rx_data=%h strobes=%0d seen=%b, required 13c 1 0", got, nstr, dut.rd_addr_seen);
        end
    endtask

    task automatic test_read_sequence();
        logic [FRAME_W-1:0] got; int lat; int nstr; spi_state_e st; logic mh;
        logic [7:0] exp;
        exp = 8'hC3;
        run_frame(10'b10_0000_0111, 1, 1'b0, got, lat, nstr, st, mh);
        checks++;
        if (got !== 10'h207 || st !== READ_ADD || dut.rd_addr_seen !== 1'b1) begin
            errors++;
            $display("FAIL rd_addr: rx_data=%h state=%0d seen=%b, required 207 READ_ADD 1", got, st, dut.rd_addr_seen);
        end
        start_frame(10'b11_0000_0000);
        checks++;
        if (dut.state !== READ_DATA || rx_valid !== 1'b1 || rx_data !== 10'h300) begin
            errors++;
            $display("FAIL rd_data_frame: state=%0d rx_valid=%b rx_data=%h, required READ_DATA 1 300", dut.state, rx_valid, rx_data);
        end
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checks++;
        if (MISO !== 1'b0 || dut.rd_addr_seen !== 1'b0) begin
            errors++;
            $display("FAIL rd_latch: MISO=%b seen=%b, required 0 0", MISO, dut.rd_addr_seen);
        end
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            checks++;
            if (MISO !== exp[i]) begin
                errors++;
                $display("FAIL miso_bit%0d: got %b, required %b", i, MISO, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL miso_after_last: got %b, required 0", MISO);
        end
        repeat (2) @(negedge clk);
        end_frame();
        run_frame(10'b10_1111_1111, 1, 1'b0, got, lat, nstr, st, mh);
        checks++;
        if (st !== READ_ADD || got !== 10'h2FF || dut.rd_addr_seen !== 1'b1) begin
            errors++;
            $display("FAIL third_read: state=%0d rx_data=%h seen=%b, required READ_ADD 2ff 1", st, got, dut.rd_addr_seen);
        end
    endtask

    task automatic test_spurious_tx();
        logic [FRAME_W-1:0] got; int lat; int nstr; spi_state_e st; logic mh;
        logic mi;
        mi = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mi = mi | MISO;
        end
        checks++;
        if (mi !== 1'b0 || dut.rd_addr_seen !== 1'b1) begin
            errors++;
            $display("FAIL spurious_idle: miso_seen=%b seen=%b, required 0 1", mi, dut.rd_addr_seen);
        end
        run_frame(10'b00_0101_0101, 4, 1'b1, got, lat, nstr, st, mh);
        checks++;
        if (mh !== 1'b0 || dut.rd_addr_seen !== 1'b1 || got !== 10'h055) begin
            errors++;
            $display("FAIL spurious_write: miso_seen=%b seen=%b rx_data=%h, required 0 1 055", mh, dut.rd_addr_seen, got);
        end
    endtask

    task automatic test_abort();
        logic [FRAME_W-1:0] w;
        logic [FRAME_W-1:0] got; int lat; int nstr; spi_state_e st; logic mh;
        int s0;
        w = 10'b01_1111_0000;
        s0 = strobe_cnt;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = FRAME_W - 1; i >= FRAME_W - 5; i--) begin
            @(negedge clk);
            MOSI = w[i];
        end
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL abort_state: state=%0d, required IDLE", dut.state);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (strobe_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL abort_strobe: %0d strobes, required 0", strobe_cnt - s0);
        end
        run_frame(10'b01_1110_0111, 1, 1'b0, got, lat, nstr, st, mh);
        checks++;
        if (got !== 10'h1E7 || nstr !== 1 || lat !== 11) begin
            errors++;
            $display("FAIL after_abort: rx_data=%h strobes=%0d lat=%0d, required 1e7 1 11", got, nstr, lat);
        end
    endtask

    task automatic test_reset_mid_read();
        int s0;
        start_frame(10'b11_0000_0001);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (MISO !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_miso: got %b, required 1", MISO);
        end
        s0 = strobe_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || dut.rd_addr_seen !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset: MISO=%b rx_valid=%b seen=%b state=%0d, required 0 0 0 IDLE", MISO, rx_valid, dut.rd_addr_seen, dut.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (strobe_cnt - s0 !== 0 || MISO !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: strobes=%0d MISO=%b, required 0 0", strobe_cnt - s0, MISO);
        end
    endtask

    task automatic test_no_double();
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL double_strobe: %0d back-to-back strobes, required 0", dbl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_sequence();
        test_spurious_tx();
        test_abort();
        test_reset_mid_read();
        test_no_double();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
